// File: rtl/jtopl_acc_sched.sv
// jtopl_acc_sched: slot scheduler for the OPL channel-sum accumulator.
// Walks the 18 operator slots, decodes sum_en/zero/rhy_IV for each issued
// slot and delays them by PIPE cenop ticks so they meet op_result.
// Optional build macro: JTOPL_ACC_MUTE_EN adds a per-channel mute input.
module jtopl_acc_sched #(
  parameter int PIPE     = 2,
  parameter int OPL_TYPE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       sync,
  input  logic       con_wr,
  input  logic [3:0] con_ch,
  input  logic       con_din,
  input  logic       rhy_en,
`ifdef JTOPL_ACC_MUTE_EN
  input  logic [8:0] mute,
`endif
  output logic [4:0] slot,
  output logic       sum_en,
  output logic       zero,
  output logic       rhy_IV,
  output logic       sample_ok
);

  // Both OPL and OPLL put the BD modulator at slot 12 in this slot map;
  // only the accumulator interprets rhy_IV differently per chip.
  localparam logic [4:0] RHY_BASE  = (OPL_TYPE == 11) ? 5'd12 : 5'd12;
  localparam logic [4:0] LAST_SLOT = 5'd17;

  // Delay-line stage layout: [2] sum_en, [1] zero, [0] rhy_IV
  logic [4:0]            slot_q, slot_d;
  logic [8:0]            con_q, con_d;
  logic                  rhy_q, rhy_d;
  logic [PIPE-1:0][2:0]  pipe_q, pipe_d;
  logic                  sample_ok_q, sample_ok_d;

  logic [3:0]            iss_ch;
  logic                  iss_sum;
  logic                  iss_zero;
  logic                  iss_rhy;

  // Issue-stage decode of the slot presented this cenop (uses current con/rhy)
  always_comb begin
    iss_ch   = slot_q[4:1];
    iss_zero = (slot_q == 5'd0);
    iss_rhy  = rhy_q && (slot_q >= RHY_BASE);
    iss_sum  = slot_q[0] ? 1'b1 : con_q[iss_ch];
    if (iss_rhy) begin
      iss_sum = (slot_q != RHY_BASE);
    end
`ifdef JTOPL_ACC_MUTE_EN
    if (mute[iss_ch]) begin
      iss_sum = 1'b0;
    end
`endif
  end

  // Next-state: slot counter, connection file, rhythm latch, delay line
  always_comb begin
    slot_d      = slot_q;
    con_d       = con_q;
    rhy_d       = rhy_q;
    pipe_d      = pipe_q;
    sample_ok_d = cenop & pipe_q[PIPE-1][1];
    if (cenop) begin
      if (slot_q == 5'd0) begin
        rhy_d = rhy_en;
      end
      for (int i = 0; i < 9; i++) begin
        if (con_wr && (con_ch == 4'(i))) begin
          con_d[i] = con_din;
        end
      end
      if (sync) begin
        slot_d = 5'd0;
        pipe_d = '0;
      end else begin
        slot_d    = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
        pipe_d[0] = {iss_sum, iss_zero, iss_rhy};
        for (int i = 1; i < PIPE; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= 5'd0;
      con_q       <= 9'd0;
      rhy_q       <= 1'b0;
      pipe_q      <= '0;
      sample_ok_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      con_q       <= con_d;
      rhy_q       <= rhy_d;
      pipe_q      <= pipe_d;
      sample_ok_q <= sample_ok_d;
    end
  end

  assign slot      = slot_q;
  assign sum_en    = pipe_q[PIPE-1][2];
  assign zero      = pipe_q[PIPE-1][1];
  assign rhy_IV    = pipe_q[PIPE-1][0];
  assign sample_ok = sample_ok_q;

endmodule

// File: tb/tb_jtopl_acc_sched.sv
// Directed bench for jtopl_acc_sched with PIPE=2 and cenop every 4 clk.
module tb_jtopl_acc_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cenop;
  logic       sync;
  logic       con_wr;
  logic [3:0] con_ch;
  logic       con_din;
  logic       rhy_en;
  logic [8:0] mute;
  logic [4:0] slot;
  logic       sum_en;
  logic       zero;
  logic       rhy_IV;
  logic       sample_ok;

  int vecs = 0;
  int errs = 0;
  int bslot;     // next slot the DUT will issue
  int last_iss;  // slot issued on the most recent cenop (-1 = flushed)
  int out_slot;  // slot whose decode is now on the outputs (-1 = none)
  int so_cnt = 0;

  jtopl_acc_sched #(.PIPE(2), .OPL_TYPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .cenop(cenop), .sync(sync),
    .con_wr(con_wr), .con_ch(con_ch), .con_din(con_din), .rhy_en(rhy_en),
`ifdef JTOPL_ACC_MUTE_EN
    .mute(mute),
`endif
    .slot(slot), .sum_en(sum_en), .zero(zero), .rhy_IV(rhy_IV),
    .sample_ok(sample_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sample_ok === 1'b1) so_cnt++;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // One cenop period (4 clk); the last negedge samples post-edge outputs.
  task automatic cyc(input logic do_sync);
    repeat (2) @(negedge clk);
    @(negedge clk);
    sync  = do_sync;
    cenop = 1'b1;
    @(negedge clk);
    cenop  = 1'b0;
    sync   = 1'b0;
    con_wr = 1'b0;
    if (do_sync) begin
      out_slot = -1;
      last_iss = -1;
      bslot    = 0;
    end else begin
      out_slot = last_iss;
      last_iss = bslot;
      bslot    = (bslot == 17) ? 0 : bslot + 1;
    end
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 18 && bslot != s; i++) cyc(1'b0);
  endtask

  task automatic tracker_reset();
    bslot = 0; last_iss = -1; out_slot = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cenop = 1'b0; sync = 1'b0; con_wr = 1'b0;
    con_ch = 4'd0; con_din = 1'b0; rhy_en = 1'b0; mute = 9'd0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({slot, sum_en, zero, rhy_IV, sample_ok} !== 9'd0) begin
      errs++;
      $display("FAIL reset_outputs got slot=%0d sum=%b zero=%b rhy=%b ok=%b exp all 0",
               slot, sum_en, zero, rhy_IV, sample_ok);
    end
    #2 rst_n = 1'b1;
    tracker_reset();
  endtask

  task automatic test_basic();
    int prev_o = -1;
    int c0 = so_cnt;
    logic [2:0] exp3;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0);
      vecs++;
      if (slot !== 5'(bslot)) begin
        errs++;
        $display("FAIL basic_slot got %0d exp %0d", slot, bslot);
      end
      exp3 = (out_slot < 0) ? 3'b000 : {out_slot[0], out_slot == 0, 1'b0};
      vecs++;
      if ({sum_en, zero, rhy_IV} !== exp3) begin
        errs++;
        $display("FAIL basic_ctl slot%0d got %b exp %b", out_slot, {sum_en, zero, rhy_IV}, exp3);
      end
      vecs++;
      if (sample_ok !== (prev_o == 0)) begin
        errs++;
        $display("FAIL basic_sample_ok after slot%0d got %b exp %b", out_slot, sample_ok, prev_o == 0);
      end
      prev_o = out_slot;
    end
    vecs++;
    if (so_cnt - c0 !== 1) begin
      errs++;
      $display("FAIL basic_sample_ok_count got %0d exp 1", so_cnt - c0);
    end
  endtask

  task automatic test_con();
    int seen6 = 0;
    goto_slot(0);
    con_ch = 4'd3; con_din = 1'b1; con_wr = 1'b1;
    cyc(1'b0);
    for (int k = 0; k < 18; k++) begin
      cyc(1'b0);
      if (out_slot == 6) begin
        vecs++;
        if (sum_en !== 1'b1) begin
          errs++;
          $display("FAIL con3_set slot6 sum_en got %b exp 1", sum_en);
        end
      end
    end
    // channel 12 does not exist and must not alias onto channel 4
    con_ch = 4'd12; con_din = 1'b1; con_wr = 1'b1;
    cyc(1'b0);
    goto_slot(10);
    con_ch = 4'd3; con_din = 1'b0; con_wr = 1'b1;
    cyc(1'b0);
    goto_slot(6);
    con_ch = 4'd3; con_din = 1'b1; con_wr = 1'b1;
    cyc(1'b0);
    for (int k = 0; k < 19; k++) begin
      cyc(1'b0);
      if (out_slot == 6) begin
        vecs++;
        if (sum_en !== (seen6 != 0)) begin
          errs++;
          $display("FAIL con_same_cenop frame%0d slot6 sum_en got %b exp %b", seen6, sum_en, seen6 != 0);
        end
        seen6++;
      end
      if (out_slot == 8) begin
        vecs++;
        if (sum_en !== 1'b0) begin
          errs++;
          $display("FAIL con_ch12_ignored slot8 sum_en got %b exp 0", sum_en);
        end
      end
    end
  endtask

  task automatic test_rhythm();
    logic [5:0] rhy_sum = 6'b111110;  // slot 17..12
    goto_slot(9);
    rhy_en = 1'b1;
    cyc(1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0);
      if (out_slot >= 12) begin
        vecs++;
        if ({sum_en, rhy_IV} !== {out_slot[0], 1'b0}) begin
          errs++;
          $display("FAIL rhy_midframe slot%0d got sum=%b rhy=%b exp sum=%b rhy=0",
                   out_slot, sum_en, rhy_IV, out_slot[0]);
        end
      end
    end
    for (int k = 0; k < 18; k++) begin
      cyc(1'b0);
      if (out_slot == 3) rhy_en = 1'b0;
      vecs++;
      if (out_slot >= 12) begin
        if ({sum_en, rhy_IV} !== {rhy_sum[out_slot-12], 1'b1}) begin
          errs++;
          $display("FAIL rhy_on slot%0d got sum=%b rhy=%b exp sum=%b rhy=1",
                   out_slot, sum_en, rhy_IV, rhy_sum[out_slot-12]);
        end
      end else if (rhy_IV !== 1'b0) begin
        errs++;
        $display("FAIL rhy_on_low slot%0d rhy_IV got %b exp 0", out_slot, rhy_IV);
      end
    end
    for (int k = 0; k < 18; k++) begin
      cyc(1'b0);
      if (out_slot >= 12) begin
        vecs++;
        if ({sum_en, rhy_IV} !== {out_slot[0], 1'b0}) begin
          errs++;
          $display("FAIL rhy_off slot%0d got sum=%b rhy=%b exp sum=%b rhy=0",
                   out_slot, sum_en, rhy_IV, out_slot[0]);
        end
      end
    end
  endtask

  task automatic test_sync();
    goto_slot(10);
    cyc(1'b1);
    vecs++;
    if ({slot, sum_en, zero, rhy_IV, sample_ok} !== 9'd0) begin
      errs++;
      $display("FAIL sync_flush got slot=%0d sum=%b zero=%b rhy=%b ok=%b exp all 0",
               slot, sum_en, zero, rhy_IV, sample_ok);
    end
    cyc(1'b0);
    vecs++;
    if ({slot, sum_en, zero} !== {5'd1, 2'b00}) begin
      errs++;
      $display("FAIL sync_gap got slot=%0d sum=%b zero=%b exp slot=1 sum=0 zero=0", slot, sum_en, zero);
    end
    cyc(1'b0);
    vecs++;
    if ({slot, sum_en, zero} !== {5'd2, 2'b01}) begin
      errs++;
      $display("FAIL sync_zero got slot=%0d sum=%b zero=%b exp slot=2 sum=0 zero=1", slot, sum_en, zero);
    end
    cyc(1'b0);
    vecs++;
    if ({sample_ok, sum_en, zero} !== 3'b110) begin
      errs++;
      $display("FAIL sync_sample_ok got ok=%b sum=%b zero=%b exp ok=1 sum=1 zero=0", sample_ok, sum_en, zero);
    end
  endtask

  task automatic test_reset_mid();
    goto_slot(5);
    vecs++;
    if (sum_en !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_pre slot3 sum_en got %b exp 1", sum_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({slot, sum_en, zero, rhy_IV, sample_ok} !== 9'd0) begin
      errs++;
      $display("FAIL rstmid_async got slot=%0d sum=%b zero=%b rhy=%b ok=%b exp all 0",
               slot, sum_en, zero, rhy_IV, sample_ok);
    end
    #1 rst_n = 1'b1;
    tracker_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0);
      if (out_slot >= 0) begin
        vecs++;
        if (sum_en !== out_slot[0]) begin
          errs++;
          $display("FAIL rstmid_con_clear slot%0d sum_en got %b exp %b", out_slot, sum_en, out_slot[0]);
        end
      end
    end
  endtask

`ifdef JTOPL_ACC_MUTE_EN
  task automatic test_mute();
    goto_slot(5);
    mute = 9'h001;
    con_ch = 4'd0; con_din = 1'b1; con_wr = 1'b1;
    cyc(1'b0);
    for (int k = 0; k < 18; k++) begin
      cyc(1'b0);
      if (out_slot == 0 || out_slot == 1) begin
        vecs++;
        if ({sum_en, zero} !== {1'b0, out_slot == 0}) begin
          errs++;
          $display("FAIL mute slot%0d got sum=%b zero=%b exp sum=0 zero=%b",
                   out_slot, sum_en, zero, out_slot == 0);
        end
      end
    end
    mute = 9'h000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_con();
    test_rhythm();
    test_sync();
    test_reset_mid();
`ifdef JTOPL_ACC_MUTE_EN
    test_mute();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/jtopl_acc_sched.md
# jtopl_acc_sched

Slot scheduler for the channel-sum accumulator. It walks the 18 operator slots of an OPL frame and generates the per-slot `sum_en`, `zero` and `rhy_IV` controls for the accumulator. The controls are delayed by the operator pipeline depth so they line up with `op_result`. It holds the per-channel connection bits and the latched rhythm-mode flag, and flags each completed output sample.

## Interface
- `PIPE`, 2: cenop ticks between a slot's issue and its `op_result` reaching the accumulator; legal range 1..7.
- `OPL_TYPE`, 1: 11 selects OPLL rhythm mapping (see Operation); any other value selects OPL.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cenop`  in  1  operator clock enable; all state advances only when high.
- `sync`  in  1  frame restart, sampled on cenop.
- `con_wr`  in  1  connection write strobe, sampled on cenop.
- `con_ch`  in  4  channel 0..8 to write; values 9..15 are ignored.
- `con_din`  in  1  connection bit: 0 = FM, 1 = additive.
- `rhy_en`  in  1  rhythm mode request.
- `mute`  in  9  per-channel mute mask; present only with `JTOPL_ACC_MUTE_EN`.
- `slot`  out  5  slot currently being issued, 0..17.
- `sum_en`  out  1  to accumulator; delayed by PIPE.
- `zero`  out  1  to accumulator; delayed by PIPE.
- `rhy_IV`  out  1  to accumulator; delayed by PIPE.
- `sample_ok`  out  1  one-clk pulse after the accumulator output updates.

## Operation
- Slot map: channel = `slot>>1`. Even slots are modulators; odd slots are carriers.
- Slot counter: advances 0→17 on each cenop, then wraps 17→0.
- Issue decode for slot s (channel c):
  - `zero` = (s==0).
  - Carrier: `sum_en` = 1.
  - Modulator: `sum_en` = `con[c]`.
- Rhythm mapping applies when the latched rhythm flag `rhy_q` = 1 and s ≥ 12:
  - `rhy_IV` = 1.
  - Slot 12 (BD modulator): `sum_en` = 0, regardless of con.
  - Slots 13..17: `sum_en` = 1.
  - When `OPL_TYPE`≠11, `rhy_IV` is still driven; the accumulator ignores it.
- `rhy_q` loads `rhy_en` only on the cenop that issues slot 0. Toggling `rhy_en` mid-frame takes effect from the next frame.
- Connection file: 9 bits, `con[con_ch]` <= `con_din` on cenop && `con_wr`.
  - A write and an issue of the same channel in the same cenop: the issue uses the old value.
- Delay line: PIPE stages of {sum_en, zero, rhy_IV}, shifting on cenop. The outputs are the last stage.
- `sync` at cenop: the counter goes to 0, so the next issued slot is 0. All delay stages clear, so no stale `zero` reaches the accumulator. `sync` has priority over the normal advance.
- `sample_ok`: registered. High for exactly one clk after a cenop edge on which output `zero`==1.

## Timing
- Reset (`rst_n` low, async): `slot`=0, all delay stages 0, `sum_en`=`zero`=`rhy_IV`=0, `con`=0, `rhy_q`=0, `sample_ok`=0. Release is async, with no clk edge required. The first cenop after release issues slot 0 (`slot` shows 0 during reset and advances to 1 on that edge).
- Latency: the decode for the slot issued on cenop n appears on the outputs after cenop n+PIPE-1. With PIPE=1, outputs are registered one cenop behind `slot`.
- Frame length: 18 cenops. `zero` is high one cenop in 18. `sample_ok` is high one clk per frame.
- cenop low: all state holds. Outputs are stable between cenops.
- Reset mid-frame: the partial frame is discarded and no `sample_ok` is issued for it.

## Configuration
- `JTOPL_ACC_MUTE_EN` defined: the `mute` port exists. The issue-stage `sum_en` is forced to 0 for every slot of channel c while `mute[c]`=1, sampled at issue time. `zero` and `rhy_IV` are unaffected.
- Undefined: no `mute` port and no gating logic. Behaviour is otherwise identical.

## Test plan
- Reset, con=0, rhy_en=0, PIPE=2, cenop every 4 clk → `sum_en` pattern per frame 0,1 repeated ×9. `zero` high on output only for slot 0, appearing 1 cenop after `slot`=0. `sample_ok` pulses once every 72 clk.
- Write con[3]=1 → slot 6 `sum_en`=1. Write con[3]=1 on the same cenop that issues slot 6 → that frame shows 0, the next frame shows 1.
- rhy_en=1 asserted while slot 9 is issuing → no effect until the next frame. Then slots 12..17 `rhy_IV`=1 and `sum_en`=0,1,1,1,1,1. Deassert → reverts at the following slot 0.
- sync pulse at slot 10 → next `slot`=0 and delay line flushed. No `zero` output for PIPE-1 cenops, then `zero` appears aligned to the new slot 0.
- Assert `rst_n`=0 mid-frame between clk edges → all outputs 0 immediately. `con` cleared, so after release all modulator slots give `sum_en`=0.
- With `JTOPL_ACC_MUTE_EN`: mute=9'h001, con[0]=1 → slots 0,1 `sum_en`=0 and slot 0 `zero` still 1.
